// File: rtl/i2s_tx_if.sv
// Sample handshake between a PCM producer and the I2S transmitter.
// Transfer happens on valid_in & ready_out; ready_out means the holding buffer is empty.
interface i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic [SAMPLE_WIDTH-1:0] left_in;
  logic [SAMPLE_WIDTH-1:0] right_in;
  logic                    valid_in;
  logic                    ready_out;

  modport master (output left_in, right_in, valid_in, input ready_out);
  modport slave  (input left_in, right_in, valid_in, output ready_out);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep holding buffer feeding left/right shift registers, BCLK/LRCLK/SDATA
// generated from clk_in by a half-period divider; frames load on the falling edge where bit_cnt wraps.
module i2s_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 16
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     enable_in,
  i2s_tx_if.slave  smp,
  output logic     bclk_out,
  output logic     lrcl_out,
  output logic     sdata_out,
  output logic     frame_start_out,
  output logic     underrun_out
);

  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = $clog2(BCLK_DIV);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DW-1:0]           r_div_cnt;
  logic [BW-1:0]           r_bit_cnt, w_bit_nxt;
  logic [SAMPLE_WIDTH-1:0] r_hold_l, r_hold_r, r_sr_l, r_sr_r;
  logic                    r_full;
  logic                    r_bclk, r_lrcl, r_sdata, r_frame_start, r_underrun;
  logic                    w_xfer, w_enter, w_leave, w_div_wrap, w_fall, w_load;
  logic                    w_right, w_shift;
  int                      w_slot_bit;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_leave     = 1'b0;
    case (r_state)
      S_IDLE: if (enable_in) begin
        w_state_nxt = S_RUN;
        w_enter     = 1'b1;
      end
      S_RUN: if (!enable_in) begin
        w_state_nxt = S_IDLE;
        w_leave     = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Falling-edge decode: everything below describes the bit that starts on this edge.
  always_comb begin
    w_xfer     = smp.valid_in && !r_full;
    w_div_wrap = (r_div_cnt == DW'(BCLK_DIV - 1));
    w_fall     = (r_state == S_RUN) && enable_in && w_div_wrap && r_bclk;
    w_bit_nxt  = (r_bit_cnt == BW'(FRAME - 1)) ? '0 : r_bit_cnt + BW'(1);
    w_load     = w_fall && (w_bit_nxt == '0);
    w_slot_bit = int'(w_bit_nxt) % SLOT_WIDTH;
    w_right    = int'(w_bit_nxt) >= SLOT_WIDTH;
    w_shift    = (w_slot_bit >= 1) && (w_slot_bit <= SAMPLE_WIDTH);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= BW'(FRAME - 1);
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_sr_l        <= '0;
      r_sr_r        <= '0;
      r_full        <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrcl        <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;

      // A load from an empty buffer can coincide with a transfer; the transfer wins the buffer.
      if (w_xfer) begin
        r_hold_l <= smp.left_in;
        r_hold_r <= smp.right_in;
        r_full   <= 1'b1;
      end else if (w_load) begin
        r_full <= 1'b0;
      end

      if (w_enter) begin
        r_div_cnt <= '0;
        r_bclk    <= 1'b0;
        r_bit_cnt <= BW'(FRAME - 1);
      end else if (w_leave) begin
        r_bclk  <= 1'b0;
        r_lrcl  <= 1'b0;
        r_sdata <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (w_div_wrap) begin
          r_div_cnt <= '0;
          r_bclk    <= ~r_bclk;
        end else begin
          r_div_cnt <= r_div_cnt + DW'(1);
        end
        if (w_fall) begin
          r_bit_cnt <= w_bit_nxt;
          r_lrcl    <= w_right;
          if (w_load) begin
            r_sr_l        <= r_full ? r_hold_l : '0;
            r_sr_r        <= r_full ? r_hold_r : '0;
            r_frame_start <= 1'b1;
            r_underrun    <= !r_full;
            r_sdata       <= 1'b0;
          end else if (w_shift && w_right) begin
            r_sdata <= r_sr_r[SAMPLE_WIDTH-1];
            r_sr_r  <= r_sr_r << 1;
          end else if (w_shift) begin
            r_sdata <= r_sr_l[SAMPLE_WIDTH-1];
            r_sr_l  <= r_sr_l << 1;
          end else begin
            r_sdata <= 1'b0;
          end
        end
      end
    end
  end

  assign smp.ready_out   = !r_full;
  assign bclk_out        = r_bclk;
  assign lrcl_out        = r_lrcl;
  assign sdata_out       = r_sdata;
  assign frame_start_out = r_frame_start;
  assign underrun_out    = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a hand-derived vector table for the first frame, targeted corner sequences,
// and a randomized run, all cross-checked every cycle against a frame-arithmetic reference model.
module tb_i2s_tx;
  localparam int SW = 24;
  localparam int SL = 32;
  localparam int D  = 16;
  localparam int FR = 2 * SL;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic bclk, lrcl, sd, fs, ur;

  always #5 clk = ~clk;

  i2s_tx_if #(.SAMPLE_WIDTH(SW)) smp ();

  i2s_tx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL), .BCLK_DIV(D)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .smp(smp),
    .bclk_out(bclk), .lrcl_out(lrcl), .sdata_out(sd),
    .frame_start_out(fs), .underrun_out(ur)
  );

  int checks = 0;
  int passed = 0;

  // Reference model state: cycles since enable, buffered pair, and pair on the wire.
  logic          m_run, m_have, m_xfer;
  int            m_k;
  logic          m_bclk, m_lrcl, m_sd, m_fs, m_ur;
  logic [SW-1:0] m_hl, m_hr, m_cl, m_cr;

  typedef struct {
    int         cyc;
    logic [4:0] exp;  // {bclk, lrcl, sdata, frame_start, underrun}
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_have = 0; m_xfer = 0; m_k = 0;
    m_bclk = 0; m_lrcl = 0; m_sd = 0; m_fs = 0; m_ur = 0;
    m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0;
  endtask

  // Advance the model across one clk edge using the inputs currently driven.
  task automatic model_edge();
    logic          xfer;
    int            f, pos, b;
    logic [SW-1:0] ch;
    xfer   = smp.valid_in && !m_have;
    m_xfer = xfer;
    m_fs   = 0;
    m_ur   = 0;
    if (!m_run) begin
      if (en) begin
        m_run = 1; m_k = 0; m_bclk = 0;
      end
    end else if (!en) begin
      m_run = 0; m_bclk = 0; m_lrcl = 0; m_sd = 0;
    end else begin
      m_k++;
      m_bclk = ((m_k / D) % 2) == 1;
      if (m_k % (2 * D) == 0) begin
        f      = m_k / (2 * D);
        pos    = (f - 1) % FR;
        m_lrcl = pos >= SL;
        b      = pos % SL;
        if (pos == 0) begin
          m_fs = 1;
          if (m_have) begin
            m_cl = m_hl; m_cr = m_hr; m_have = 0;
          end else begin
            m_cl = '0; m_cr = '0; m_ur = 1;
          end
        end
        ch   = m_lrcl ? m_cr : m_cl;
        m_sd = (b >= 1 && b <= SW) ? ch[SW-b] : 1'b0;
      end
    end
    if (xfer) begin
      m_have = 1; m_hl = smp.left_in; m_hr = smp.right_in;
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({bclk, lrcl, sd, fs, ur, smp.ready_out});
  endfunction

  function automatic logic [31:0] model_vec();
    return 32'({m_bclk, m_lrcl, m_sd, m_fs, m_ur, !m_have});
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("outputs", dut_vec(), model_vec());
  endtask

  function automatic logic next_is_load();
    return m_run && en && ((m_k + 1) % (2 * D) == 0) && ((((m_k + 1) / (2 * D)) - 1) % FR == 0);
  endfunction

  task automatic put(input logic [SW-1:0] l, input logic [SW-1:0] r);
    smp.valid_in = 1'b1;
    smp.left_in  = l;
    smp.right_in = r;
  endtask

  initial begin
    int            c;
    logic          found;
    logic [SW-1:0] bl, br;

    tbl[0]  = '{16,   5'b10000};
    tbl[1]  = '{31,   5'b10000};
    tbl[2]  = '{32,   5'b00010};
    tbl[3]  = '{33,   5'b00000};
    tbl[4]  = '{64,   5'b00100};
    tbl[5]  = '{80,   5'b10100};
    tbl[6]  = '{96,   5'b00000};
    tbl[7]  = '{128,  5'b00100};
    tbl[8]  = '{800,  5'b00100};
    tbl[9]  = '{832,  5'b00000};
    tbl[10] = '{1024, 5'b00000};
    tbl[11] = '{1056, 5'b01000};
    tbl[12] = '{1088, 5'b01000};
    tbl[13] = '{1184, 5'b01100};
    tbl[14] = '{1792, 5'b01100};
    tbl[15] = '{2048, 5'b01000};
    tbl[16] = '{2080, 5'b00011};

    rst = 1'b1; en = 1'b0;
    smp.valid_in = 1'b0; smp.left_in = '0; smp.right_in = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", dut_vec(), 32'b000001);
    rst = 1'b0;

    // Basic frame from the vector table.
    put(24'hABCDEF, 24'h123456);
    step();
    smp.valid_in = 1'b0;
    en = 1'b1;
    step();
    c = 0;
    for (int i = 0; i < 17; i++) begin
      while (c < tbl[i].cyc) begin
        step();
        c++;
      end
      check($sformatf("vec%0d", i), 32'({bclk, lrcl, sd, fs, ur}), 32'(tbl[i].exp));
    end

    // Back-pressure: A accepted, B held on valid until the buffer frees.
    put(24'h5A5A5A, 24'hC3C3C3);
    step();
    bl = 24'($urandom); br = 24'($urandom);
    put(bl, br);
    found = 1'b0;
    for (int i = 0; i < 2200 && !found; i++) begin
      step();
      if (m_xfer) found = 1'b1;
    end
    check("backpressure_accept", 32'(found), 32'd1);
    smp.valid_in = 1'b0;
    for (int i = 0; i < 4200; i++) step();

    // Boundary collision: transfer lands on an empty-buffer frame load.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (next_is_load() && !m_have) found = 1'b1;
      else step();
    end
    check("collision_reached", 32'(found), 32'd1);
    put(24'($urandom), 24'($urandom));
    step();
    smp.valid_in = 1'b0;
    check("collision", 32'({fs, ur, smp.ready_out}), 32'b110);
    found = 1'b0;
    for (int i = 0; i < 2100 && !found; i++) begin
      step();
      if (m_fs) found = 1'b1;
    end
    check("collision_next_frame", 32'({found, ur}), 32'b10);

    // Enable drop mid-left slot, held sample survives re-enable.
    put(24'hF0F00F, 24'h0FF0F0);
    step();
    smp.valid_in = 1'b0;
    for (int i = 0; i < 300; i++) step();
    en = 1'b0;
    step();
    check("enable_drop", 32'({bclk, lrcl, sd, smp.ready_out}), 32'b0000);
    for (int i = 0; i < 5; i++) step();
    en = 1'b1;
    step();
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 31) check("reenable_early", 32'(fs), 32'd0);
      if (i == 32) check("reenable_fs", 32'({fs, ur}), 32'b10);
    end
    for (int i = 0; i < 2100; i++) step();

    // Randomized traffic with occasional enable drops.
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 1499) == 0) put(24'($urandom), 24'($urandom));
      else smp.valid_in = 1'b0;
      if (en && $urandom_range(0, 7999) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 20) == 0) en = 1'b1;
      step();
    end

    // Asynchronous reset mid-frame with a full buffer.
    en = 1'b1;
    smp.valid_in = 1'b0;
    for (int i = 0; i < 100; i++) step();
    put(24'h777777, 24'h888888);
    for (int i = 0; i < 3 && !m_have; i++) step();
    smp.valid_in = 1'b0;
    for (int i = 0; i < 40; i++) step();
    #2 rst = 1'b1;
    #1 check("async_reset", dut_vec(), 32'b000001);
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
